// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg
//   Shared types and constants for the BCD stopwatch controller:
//   - sw_state_e  : controller state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   - bcd_digit_t : one 4-bit BCD digit
//   - BCD_MAX     : largest legal digit value (9)
//   - bcd_inc()   : single-digit BCD increment with 9->0 wrap
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt
//   One decade of the BCD count. Counts 0..9 and wraps to 0.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-low reset (q -> 0)
//     en     in   advance by one on this edge
//     clr    in   synchronous clear to 0, dominates en
//     q      out  registered digit value
//     max    out  q == 9, used to enable the next higher digit
module bcd_digit_cnt
    import bcd_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output bcd_digit_t q,
    output logic       max
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= bcd_inc(q);
        end
    end

    assign max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
//   Three-digit BCD stopwatch with a clock prescaler, a start/stop/clear
//   command FSM and a target value that ends the run.
//   Commands are plain levels sampled on every rising edge; there is no
//   handshake: a command is acted on in every cycle it is high and the
//   current state accepts it. Priority: clear > limit match > stop > start.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     start      in   IDLE/PAUSE -> RUN (limit is latched on IDLE -> RUN)
//     stop       in   RUN -> PAUSE
//     clear      in   any state -> IDLE, count 000
//     limit      in   BCD target {hundreds, tens, ones}
//     d1/d10/d100 out registered BCD count digits
//     tick       out  combinational count strobe (RUN and prescaler at DIV-1)
//     running    out  registered, high in RUN
//     done       out  registered, high in DONE
//     dbg_state  out  current FSM state, for observation only
module bcd_stopwatch_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [11:0] limit,
    output bcd_digit_t  d1,
    output bcd_digit_t  d10,
    output bcd_digit_t  d100,
    output logic        tick,
    output logic        running,
    output logic        done,
    output sw_state_e   dbg_state
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    sw_state_e   state;
    logic [PW-1:0] presc;
    logic [11:0] lim_q;
    logic        max1, max10, max100;
    bcd_digit_t  n1, n10, n100;
    logic        match;

    assign dbg_state = state;
    assign tick      = (state == RUN) && (presc == PRESC_LAST);

    // Ripple enable: a digit advances only when every lower digit is at 9.
    bcd_digit_cnt u_ones (
        .clock (clock), .reset (reset), .en (tick),
        .clr (clear), .q (d1), .max (max1)
    );
    bcd_digit_cnt u_tens (
        .clock (clock), .reset (reset), .en (tick && max1),
        .clr (clear), .q (d10), .max (max10)
    );
    bcd_digit_cnt u_hundreds (
        .clock (clock), .reset (reset), .en (tick && max1 && max10),
        .clr (clear), .q (d100), .max (max100)
    );

    // Post-increment count, so the match lands on the value the digits
    // are about to take. Digits never exceed 9, so a limit with an
    // out-of-range digit can never match.
    assign n1    = bcd_inc(d1);
    assign n10   = max1 ? bcd_inc(d10) : d10;
    assign n100  = (max1 && max10) ? bcd_inc(d100) : d100;
    assign match = tick && ({n100, n10, n1} == lim_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            lim_q   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    presc <= '0;
                    if (start) begin
                        state   <= RUN;
                        lim_q   <= limit;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (match) begin
                        state   <= DONE;
                        presc   <= '0;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        // The prescaler keeps advancing on the stop edge, so
                        // a later resume continues the partial period.
                        presc <= tick ? '0 : presc + PW'(1);
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    presc <= '0;
                end
                default: begin
                    state   <= IDLE;
                    presc   <= '0;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl
//   Drives two instances (DIV=4 and DIV=1) with the same commands. A
//   decimal reference model predicts each post-edge output vector
//   {d100, d10, d1, tick, running, done}; a monitor pops and compares.
module tb_bcd_stopwatch_ctrl;
    import bcd_ctrl_pkg::*;

    localparam int W = 15;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop, clear;
    logic [11:0] limit;

    logic [3:0] a_d1, a_d10, a_d100, b_d1, b_d10, b_d100;
    logic       a_tick, a_running, a_done, b_tick, b_running, b_done;
    sw_state_e  a_state, b_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int m_mode[2];
    int m_pre[2];
    int m_cnt[2];
    int m_lim[2];
    int m_div[2];

    bcd_stopwatch_ctrl #(.DIV(4)) u_dut4 (
        .clock (clock), .reset (reset), .start (start), .stop (stop),
        .clear (clear), .limit (limit), .d1 (a_d1), .d10 (a_d10),
        .d100 (a_d100), .tick (a_tick), .running (a_running),
        .done (a_done), .dbg_state (a_state)
    );

    bcd_stopwatch_ctrl #(.DIV(1)) u_dut1 (
        .clock (clock), .reset (reset), .start (start), .stop (stop),
        .clear (clear), .limit (limit), .d1 (b_d1), .d10 (b_d10),
        .d100 (b_d100), .tick (b_tick), .running (b_running),
        .done (b_done), .dbg_state (b_state)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic int lim_dec(input logic [11:0] l);
        if (l[11:8] > 4'd9 || l[7:4] > 4'd9 || l[3:0] > 4'd9) return -1;
        return int'(l[11:8]) * 100 + int'(l[7:4]) * 10 + int'(l[3:0]);
    endfunction

    function automatic logic [W-1:0] model_out(input int k);
        logic [3:0] h, t, o;
        logic tk, rn, dn;
        h  = 4'(m_cnt[k] / 100);
        t  = 4'((m_cnt[k] / 10) % 10);
        o  = 4'(m_cnt[k] % 10);
        tk = (m_mode[k] == S_RUN) && (m_pre[k] == m_div[k] - 1);
        rn = (m_mode[k] == S_RUN);
        dn = (m_mode[k] == S_DONE);
        return {h, t, o, tk, rn, dn};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = S_IDLE;
            m_pre[k]  = 0;
            m_cnt[k]  = 0;
            m_lim[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit s, input bit st, input bit cl,
                              input logic [11:0] l);
        bit tk;
        tk = (m_mode[k] == S_RUN) && (m_pre[k] == m_div[k] - 1);
        if (cl) begin
            m_mode[k] = S_IDLE;
            m_pre[k]  = 0;
            m_cnt[k]  = 0;
        end else begin
            case (m_mode[k])
                S_IDLE: begin
                    m_pre[k] = 0;
                    if (s) begin
                        m_mode[k] = S_RUN;
                        m_lim[k]  = lim_dec(l);
                    end
                end
                S_RUN: begin
                    if (tk) m_cnt[k] = (m_cnt[k] + 1) % 1000;
                    if (tk && m_cnt[k] == m_lim[k]) begin
                        m_mode[k] = S_DONE;
                        m_pre[k]  = 0;
                    end else begin
                        m_pre[k] = (m_pre[k] + 1) % m_div[k];
                        if (st) m_mode[k] = S_PAUSE;
                    end
                end
                S_PAUSE: if (s) m_mode[k] = S_RUN;
                default: ;
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit s, input bit st, input bit cl, input logic [11:0] l);
        @(negedge clock);
        start = s;
        stop  = st;
        clear = cl;
        limit = l;
        for (int k = 0; k < 2; k++) model_step(k, s, st, cl, l);
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, limit);
    endtask

    task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        compare({tag, "_dut4_zero"}, {a_d100, a_d10, a_d1, a_tick, a_running, a_done}, '0);
        compare({tag, "_dut1_zero"}, {b_d100, b_d10, b_d1, b_tick, b_running, b_done}, '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                compare("dut4_out", {a_d100, a_d10, a_d1, a_tick, a_running, a_done}, e);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                compare("dut1_out", {b_d100, b_d10, b_d1, b_tick, b_running, b_done}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_div[0] = 4;
        m_div[1] = 1;
        model_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        limit = 12'h000;
        #1;
        check_zero("por");
        @(negedge clock);
        reset = 1'b1;

        // Run to limit 012 and stay frozen there.
        cycle(1'b1, 1'b0, 1'b0, 12'h012);
        idle(60);
        cycle(1'b0, 1'b0, 1'b1, limit);

        // Stop, pause, resume mid prescaler period.
        cycle(1'b1, 1'b0, 1'b0, 12'h999);
        idle(5);
        cycle(1'b0, 1'b1, 1'b0, limit);
        idle(13);
        cycle(1'b1, 1'b0, 1'b0, limit);
        idle(10);

        // clear, stop and start together while running.
        idle(30);
        cycle(1'b1, 1'b1, 1'b1, limit);
        idle(3);

        // Limit changes after start are ignored.
        cycle(1'b1, 1'b0, 1'b0, 12'h005);
        cycle(1'b0, 1'b0, 1'b0, 12'h003);
        idle(30);
        cycle(1'b0, 1'b0, 1'b1, limit);

        // Limit 000: full wrap through 999 before done.
        cycle(1'b1, 1'b0, 1'b0, 12'h000);
        idle(4010);
        cycle(1'b0, 1'b0, 1'b1, limit);

        // Out-of-range digit never matches; wraps past 999.
        cycle(1'b1, 1'b0, 1'b0, 12'hA00);
        idle(1100);

        // Asynchronous reset between edges mid-run.
        cycle(1'b0, 1'b0, 1'b1, limit);
        cycle(1'b1, 1'b0, 1'b0, 12'hFFF);
        idle(780);
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("mid_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 12'h020);
        idle(100);

        // Randomized commands and limits.
        for (int i = 0; i < 2500; i++) begin
            logic [11:0] l;
            int v;
            if ($urandom_range(0, 3) == 0) begin
                l = 12'($urandom_range(0, 4095));
            end else begin
                v = $urandom_range(0, 39);
                l = {4'd0, 4'(v / 10), 4'(v % 10)};
            end
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 59) == 0, l);
        end

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d left want 0", exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
